// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and frame sizing.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared, ticks on the last count.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input and a one-entry holding register
// so consecutive frames run back-to-back without an idle gap.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_serial,
    output logic              o_tx_active,
    output logic              o_tx_done
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be 2..65535");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
    // Bit positions within a frame: 0 = start, 1..DATA_W = data, then parity/stop.
    localparam logic [3:0] POS_LAST_DATA = 4'(DATA_W);
    localparam logic [3:0] POS_LAST      = 4'(FRAME_BITS - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              ready_q;
    logic              par_q;
    logic              serial_q;
    logic              active_q;
    logic              done_q;
    logic [3:0]        bit_pos;
    logic              tick;

    logic              in_idle;
    logic              accept;
    logic              last_stop;
    logic              start_frame;
    logic              hold_full_nxt;
    logic [DATA_W-1:0] next_data;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (PARITY == PAR_EVEN) ? ^d : ~^d;
    endfunction

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(i_rst_n),
        .clr  (in_idle),
        .tick (tick)
    );

    always_comb begin
        in_idle     = (state == ST_IDLE);
        accept      = i_tx_valid && ready_q;
        last_stop   = (state == ST_STOP) && tick && (bit_pos == POS_LAST);
        start_frame = (in_idle && (accept || hold_full)) || (last_stop && hold_full);
        next_data   = hold_full ? hold : i_tx_data;

        // In IDLE an accepted byte bypasses the holding register straight into the shifter.
        hold_full_nxt = hold_full;
        if (accept && !in_idle) begin
            hold_full_nxt = 1'b1;
        end else if (start_frame && hold_full) begin
            hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ready_q   <= 1'b0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            bit_pos   <= '0;
        end else begin
            done_q    <= last_stop;
            hold_full <= hold_full_nxt;
            ready_q   <= !hold_full_nxt;
            if (accept && !in_idle) begin
                hold <= i_tx_data;
            end

            if (start_frame) begin
                state    <= ST_START;
                shreg    <= next_data;
                par_q    <= parity_of(next_data);
                bit_pos  <= '0;
                serial_q <= 1'b0;
                active_q <= 1'b1;
            end else if (last_stop) begin
                state    <= ST_IDLE;
                bit_pos  <= '0;
                serial_q <= 1'b1;
                active_q <= 1'b0;
            end else if (tick) begin
                bit_pos <= bit_pos + 4'd1;
                case (state)
                    ST_START, ST_DATA: begin
                        if (bit_pos == POS_LAST_DATA) begin
                            if (PARITY != PAR_NONE) begin
                                state    <= ST_PARITY;
                                serial_q <= par_q;
                            end else begin
                                state    <= ST_STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            state    <= ST_DATA;
                            serial_q <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state    <= ST_STOP;
                        serial_q <= 1'b1;
                    end
                    ST_STOP: begin
                        serial_q <= 1'b1;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        serial_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_tx_ready  = ready_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8E1, 8O1, 8N1, 7N2) at 4 clocks per bit,
// checked every cycle against a frame-level model plus hand-computed line patterns.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] v;
    logic [8:0] d [4];
    logic [3:0] rdy, ser, act, dn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .i_rst_n(rst_n), .i_tx_valid(v[0]), .o_tx_ready(rdy[0]),
        .i_tx_data(d[0][7:0]), .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .i_rst_n(rst_n), .i_tx_valid(v[1]), .o_tx_ready(rdy[1]),
        .i_tx_data(d[1][7:0]), .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .i_rst_n(rst_n), .i_tx_valid(v[2]), .o_tx_ready(rdy[2]),
        .i_tx_data(d[2][7:0]), .o_tx_serial(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .i_rst_n(rst_n), .i_tx_valid(v[3]), .o_tx_ready(rdy[3]),
        .i_tx_data(d[3][6:0]), .o_tx_serial(ser[3]), .o_tx_active(act[3]), .o_tx_done(dn[3]));

    function automatic int cfg_w(input int k);
        return (k == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_p(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 0);
    endfunction

    function automatic int cfg_s(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + cfg_w(k) + ((cfg_p(k) != 0) ? 1 : 0) + cfg_s(k);
    endfunction

    // Line levels of one frame, index 0 = start bit; unused upper positions stay 1.
    function automatic logic [15:0] frame_of(input int k, input logic [8:0] dat);
        logic [15:0] f;
        logic        x;
        f    = '1;
        f[0] = 1'b0;
        x    = 1'b0;
        for (int i = 0; i < cfg_w(k); i++) begin
            f[1 + i] = dat[i];
            x        = x ^ dat[i];
        end
        if (cfg_p(k) == 2) f[cfg_w(k) + 1] = x;
        if (cfg_p(k) == 1) f[cfg_w(k) + 1] = ~x;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Frame-level model: elapsed clocks into the current frame select the expected line bit.
    logic        mv = 1'b0;
    logic [3:0]  busy_m, hv_m, rdy_m, done_m;
    int          el_m [4];
    logic [15:0] fr_m [4];
    logic [8:0]  hd_m [4];
    logic        m_acc;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                busy_m[k] = 1'b0;
                hv_m[k]   = 1'b0;
                rdy_m[k]  = 1'b0;
                done_m[k] = 1'b0;
                el_m[k]   = 0;
                mv        = 1'b1;
            end else if (mv) begin
                m_acc     = v[k] && rdy_m[k];
                done_m[k] = 1'b0;
                if (busy_m[k]) begin
                    el_m[k]++;
                    if (el_m[k] == frame_len(k) * CPB) begin
                        done_m[k] = 1'b1;
                        busy_m[k] = 1'b0;
                        if (hv_m[k]) begin
                            busy_m[k] = 1'b1;
                            el_m[k]   = 0;
                            fr_m[k]   = frame_of(k, hd_m[k]);
                            hv_m[k]   = 1'b0;
                        end
                    end
                    if (m_acc) begin
                        hv_m[k] = 1'b1;
                        hd_m[k] = d[k];
                    end
                end else if (hv_m[k]) begin
                    busy_m[k] = 1'b1;
                    el_m[k]   = 0;
                    fr_m[k]   = frame_of(k, hd_m[k]);
                    hv_m[k]   = 1'b0;
                end else if (m_acc) begin
                    busy_m[k] = 1'b1;
                    el_m[k]   = 0;
                    fr_m[k]   = frame_of(k, d[k]);
                end
                rdy_m[k] = !hv_m[k];
            end
        end
    end

    logic es;
    always @(negedge clk) begin
        if (mv) begin
            for (int k = 0; k < 4; k++) begin
                es = busy_m[k] ? fr_m[k][el_m[k] / CPB] : 1'b1;
                chk($sformatf("dut%0d serial t=%0t", k, $time), 32'(ser[k]), 32'(es));
                chk($sformatf("dut%0d active t=%0t", k, $time), 32'(act[k]), 32'(busy_m[k]));
                chk($sformatf("dut%0d done t=%0t", k, $time), 32'(dn[k]), 32'(done_m[k]));
                chk($sformatf("dut%0d ready t=%0t", k, $time), 32'(rdy[k]), 32'(rdy_m[k]));
            end
        end
    end

    // Single frame from idle; line holds the hand-computed level of each frame bit.
    task automatic run_frame(input int k, input logic [8:0] dat, input int nb,
                             input logic [15:0] line, input string tag);
        int   act_n = 0, first_a = 0, last_a = 0, done_n = 0, done_at = 0, ser_bad = 0;
        logic eb;
        @(negedge clk);
        chk({tag, " ready before send"}, 32'(rdy[k]), 32'd1);
        v[k] = 1'b1;
        d[k] = dat;
        for (int n = 1; n <= nb * CPB + 4; n++) begin
            @(negedge clk);
            if (n == 1) v[k] = 1'b0;
            eb = (n <= nb * CPB) ? line[(n - 1) / CPB] : 1'b1;
            if (ser[k] !== eb) ser_bad++;
            if (act[k] === 1'b1) begin
                act_n++;
                if (first_a == 0) first_a = n;
                last_a = n;
            end
            if (dn[k] === 1'b1) begin
                done_n++;
                done_at = n;
            end
        end
        chk({tag, " line pattern errors"}, 32'(ser_bad), 32'd0);
        chk({tag, " active clocks"}, 32'(act_n), 32'(nb * CPB));
        chk({tag, " first active clock"}, 32'(first_a), 32'd1);
        chk({tag, " last active clock"}, 32'(last_a), 32'(nb * CPB));
        chk({tag, " done pulses"}, 32'(done_n), 32'd1);
        chk({tag, " done clock"}, 32'(done_at), 32'(nb * CPB + 1));
    endtask

    task automatic run_b2b();
        logic [7:0]   bytes [3];
        int           acc_at [3];
        int           done_at [3];
        int           i = 0, act_n = 0, first_a = 0, last_a = 0, done_n = 0, ser_bad = 0;
        logic         pend = 1'b0;
        logic [29:0]  line;
        logic [127:0] rdy_tr;
        bytes[0] = 8'h55;
        bytes[1] = 8'h0F;
        bytes[2] = 8'h33;
        line     = {10'b1001100110, 10'b1000011110, 10'b1010101010};
        for (int j = 0; j < 3; j++) begin
            acc_at[j]  = -1;
            done_at[j] = -1;
        end
        rdy_tr = '0;
        @(negedge clk);
        v[2] = 1'b1;
        d[2] = {1'b0, bytes[0]};
        for (int n = 0; n <= 126; n++) begin
            if (n > 0) @(negedge clk);
            if (pend) begin
                i++;
                if (i < 3) d[2] = {1'b0, bytes[i]};
                else v[2] = 1'b0;
            end
            rdy_tr[n] = rdy[2];
            if (n >= 1 && n <= 120 && ser[2] !== line[(n - 1) / CPB]) ser_bad++;
            if (act[2] === 1'b1) begin
                act_n++;
                if (first_a == 0) first_a = n;
                last_a = n;
            end
            if (dn[2] === 1'b1) begin
                if (done_n < 3) done_at[done_n] = n;
                done_n++;
            end
            pend = v[2] && rdy[2];
            if (pend && i < 3) acc_at[i] = n;
        end
        chk("b2b accept 1 clock", 32'(acc_at[0]), 32'd0);
        chk("b2b accept 2 clock", 32'(acc_at[1]), 32'd1);
        chk("b2b accept 3 clock", 32'(acc_at[2]), 32'd41);
        chk("b2b ready stalled early", 32'(rdy_tr[2]), 32'd0);
        chk("b2b ready stalled late", 32'(rdy_tr[40]), 32'd0);
        chk("b2b ready after frame 1", 32'(rdy_tr[41]), 32'd1);
        chk("b2b done pulses", 32'(done_n), 32'd3);
        chk("b2b done 1 clock", 32'(done_at[0]), 32'd41);
        chk("b2b done 2 clock", 32'(done_at[1]), 32'd81);
        chk("b2b done 3 clock", 32'(done_at[2]), 32'd121);
        chk("b2b active clocks", 32'(act_n), 32'd120);
        chk("b2b first active", 32'(first_a), 32'd1);
        chk("b2b last active", 32'(last_a), 32'd120);
        chk("b2b line pattern errors", 32'(ser_bad), 32'd0);
    endtask

    task automatic run_reset_mid();
        int busy_n = 0;
        @(negedge clk);
        v[0] = 1'b1;
        d[0] = 9'h03C;
        @(negedge clk);
        d[0] = 9'h081;
        @(negedge clk);
        v[0] = 1'b0;
        chk("rst-mid holding full ready", 32'(rdy[0]), 32'd0);
        repeat (15) @(negedge clk);
        chk("rst-mid data bit 3 level", 32'(ser[0]), 32'd1);
        chk("rst-mid active before reset", 32'(act[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst-mid serial", 32'(ser[0]), 32'd1);
        chk("rst-mid active", 32'(act[0]), 32'd0);
        chk("rst-mid done", 32'(dn[0]), 32'd0);
        chk("rst-mid ready in reset", 32'(rdy[0]), 32'd0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (act[0] !== 1'b0 || dn[0] !== 1'b0) busy_n++;
        end
        chk("rst-mid holding flushed", 32'(busy_n), 32'd0);
        chk("rst-mid ready after release", 32'(rdy[0]), 32'd1);
        run_frame(0, 9'h0A5, 11, 16'b0000_0101_0100_1010, "8E1 after reset");
    endtask

    initial begin
        int quiet_n = 0;
        rst_n = 1'b0;
        v     = '0;
        for (int k = 0; k < 4; k++) d[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset dut%0d serial", k), 32'(ser[k]), 32'd1);
            chk($sformatf("reset dut%0d active", k), 32'(act[k]), 32'd0);
            chk($sformatf("reset dut%0d done", k), 32'(dn[k]), 32'd0);
            chk($sformatf("reset dut%0d ready", k), 32'(rdy[k]), 32'd0);
        end
        v = 4'hF;
        for (int k = 0; k < 4; k++) d[k] = 9'h1FF;
        @(negedge clk);
        v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (act !== 4'h0 || dn !== 4'h0) quiet_n++;
        end
        chk("valid while not ready ignored", 32'(quiet_n), 32'd0);
        chk("ready after release", 32'(rdy), 32'hF);

        run_frame(0, 9'h0A5, 11, 16'b0000_0101_0100_1010, "8E1 A5");
        run_frame(1, 9'h000, 11, 16'b0000_0110_0000_0000, "8O1 00");
        run_frame(2, 9'h000, 10, 16'b0000_0010_0000_0000, "8N1 00");
        run_frame(3, 9'h0FF, 10, 16'b0000_0011_1111_1110, "7N2 7F");
        run_b2b();
        run_reset_mid();

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
